// File: rtl/sobol_multidim_gen.sv
// Multi-dimensional Gray-code Sobol generator with loadable direction numbers and a valid/ready output.
// Define SOBOL_SCRAMBLE_EN to add a per-dimension random digital shift loaded through scr_we/scr_data.
module sobol_multidim_gen #(
    parameter int WIDTH = 32,
    parameter int DIMS  = 4,
    parameter int DIM_W = 2,
    parameter int BIT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clr,
    input  logic [WIDTH-1:0]      num_pts,
    input  logic                  dir_we,
    input  logic [DIM_W-1:0]      dir_dim,
    input  logic [BIT_W-1:0]      dir_bit,
    input  logic [WIDTH-1:0]      dir_data,
`ifdef SOBOL_SCRAMBLE_EN
    input  logic                  scr_we,
    input  logic [WIDTH-1:0]      scr_data,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMS*WIDTH-1:0] out_data,
    output logic [WIDTH-1:0]      out_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] x    [DIMS];
    logic [WIDTH-1:0] v    [DIMS][WIDTH];
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] npts;
    logic             wrap_q;
    logic             hs;
    logic             last_pt;
    logic             idx_full;
    logic [BIT_W-1:0] c;
    logic             tbl_wr;

    function automatic logic [BIT_W-1:0] lowest_zero(input logic [WIDTH-1:0] val);
        lowest_zero = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (!val[i]) lowest_zero = BIT_W'(i);
    endfunction

    assign hs       = out_valid && out_ready;
    assign last_pt  = (npts != '0) && (idx == npts - WIDTH'(1));
    assign idx_full = &idx;
    assign c        = lowest_zero(idx);
    assign tbl_wr   = (state == ST_IDLE) && !clr && (32'(dir_dim) < DIMS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_RUN;
                ST_RUN:  if (hs && last_pt) state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == ST_RUN);
        busy      = (state == ST_RUN);
        done      = (state == ST_DONE);
        wrap      = wrap_q;
        out_idx   = idx;
    end

    // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            npts   <= '0;
            wrap_q <= 1'b0;
            for (int d = 0; d < DIMS; d++) x[d] <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (clr) begin
                idx <= '0;
                for (int d = 0; d < DIMS; d++) x[d] <= '0;
            end else if (state == ST_IDLE && start) begin
                npts <= num_pts;
                idx  <= '0;
                for (int d = 0; d < DIMS; d++) x[d] <= '0;
            end else if (hs) begin
                if (npts == '0 && idx_full) begin
                    idx    <= '0;
                    wrap_q <= 1'b1;
                    for (int d = 0; d < DIMS; d++) x[d] <= '0;
                end else begin
                    idx <= idx + WIDTH'(1);
                    for (int d = 0; d < DIMS; d++) x[d] <= x[d] ^ v[d][c];
                end
            end
        end
    end

    // NOTE: the direction table must return to van der Corput on reset, so it is built from flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DIMS; d++)
                for (int k = 0; k < WIDTH; k++)
                    v[d][k] <= WIDTH'(1) << (WIDTH - 1 - k);
        end else if (dir_we && tbl_wr && (32'(dir_bit) < WIDTH)) begin
            v[dir_dim][dir_bit] <= dir_data;
        end
    end

`ifdef SOBOL_SCRAMBLE_EN
    logic [WIDTH-1:0] s [DIMS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DIMS; d++) s[d] <= '0;
        end else if (scr_we && tbl_wr) begin
            s[dir_dim] <= scr_data;
        end
    end
`endif

    for (genvar d = 0; d < DIMS; d++) begin : g_out
`ifdef SOBOL_SCRAMBLE_EN
        assign out_data[d*WIDTH +: WIDTH] = x[d] ^ s[d];
`else
        assign out_data[d*WIDTH +: WIDTH] = x[d];
`endif
    end

endmodule

// File: tb/tb_sobol_multidim_gen.sv
// Scoreboard bench for sobol_multidim_gen: a 32-bit two-dimension instance and a 4-bit one-dimension
// instance for index wrap; expected points are hand-computed top-nibble tables.
module tb_sobol_multidim_gen;

    typedef struct {
        logic [31:0] idx;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, clr = 1'b0, dir_we = 1'b0, out_ready = 1'b0;
    logic [31:0] num_pts = '0, dir_data = '0;
    logic [1:0]  dir_dim = '0;
    logic [4:0]  dir_bit = '0;
    logic        out_valid, busy, done, wrap;
    logic [63:0] out_data;
    logic [31:0] out_idx;

    logic        s_start = 1'b0, s_clr = 1'b0, s_ready = 1'b0;
    logic [3:0]  s_num_pts = '0;
    logic        s_valid, s_busy, s_done, s_wrap;
    logic [3:0]  s_data, s_idx;

    exp_t        exp_q[$];
    exp_t        s_q[$];
    int          n_vec = 0, n_bad = 0;
    int          done_cnt = 0, wrap_cnt = 0;
    logic        hs_prev = 1'b0;

    always #5 clk = ~clk;

    sobol_multidim_gen #(.WIDTH(32), .DIMS(2), .DIM_W(2), .BIT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .num_pts(num_pts),
        .dir_we(dir_we), .dir_dim(dir_dim), .dir_bit(dir_bit), .dir_data(dir_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .wrap(wrap)
    );

    sobol_multidim_gen #(.WIDTH(4), .DIMS(1), .DIM_W(1), .BIT_W(2)) dut4 (
        .clk(clk), .rst(rst), .start(s_start), .clr(s_clr), .num_pts(s_num_pts),
        .dir_we(1'b0), .dir_dim(1'b0), .dir_bit(2'd0), .dir_data(4'd0),
        .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data), .out_idx(s_idx),
        .busy(s_busy), .done(s_done), .wrap(s_wrap)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare every presented point against the queue head; pop only on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) check("unexpected_point", {32'd0, out_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    check("point_idx", {32'd0, out_idx}, {32'd0, exp_q[0].idx});
                    check("point_data", out_data, exp_q[0].data);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_hs", {63'd0, hs_prev}, 64'd1);
                check("valid_low_in_done", {63'd0, out_valid}, 64'd0);
            end
            hs_prev = out_valid && out_ready;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid) begin
                if (s_q.size() == 0) check("w4_unexpected_point", {60'd0, s_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    check("w4_idx", {60'd0, s_idx}, {32'd0, s_q[0].idx});
                    check("w4_data", {60'd0, s_data}, s_q[0].data);
                    if (s_ready) void'(s_q.pop_front());
                end
            end
            if (s_wrap) begin
                wrap_cnt++;
                check("wrap_idx_zero", {60'd0, s_idx}, 64'd0);
                check("wrap_data_zero", {60'd0, s_data}, 64'd0);
                check("wrap_busy", {63'd0, s_busy}, 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [3:0] n0, input logic [3:0] n1);
        exp_t e;
        e.idx  = 32'(i);
        e.data = {n1, 28'd0, n0, 28'd0};
        exp_q.push_back(e);
    endtask

    task automatic write_dir(input logic [1:0] d, input logic [4:0] k, input logic [31:0] val);
        dir_we = 1'b1; dir_dim = d; dir_bit = k; dir_data = val;
        tick();
        dir_we = 1'b0;
    endtask

    task automatic begin_run(input logic [31:0] n, input logic rdy);
        start = 1'b1; num_pts = n; out_ready = rdy;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int i = 0;
        while (!done && i < max) begin
            tick();
            i++;
        end
        check({name, "_done_seen"}, {63'd0, done}, 64'd1);
        tick();
        check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
        check({name, "_idle_after"}, {63'd0, busy}, 64'd0);
        check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [3:0] vdc   [8] = '{4'h0, 4'h8, 4'hC, 4'h4, 4'h6, 4'hE, 4'hA, 4'h2};
        logic [3:0] tbl1  [8] = '{4'h0, 4'h8, 4'h4, 4'hC, 4'h6, 4'hE, 4'h2, 4'hA};
        logic [3:0] w4seq [18] = '{4'h0, 4'h8, 4'hC, 4'h4, 4'h6, 4'hE, 4'hA, 4'h2, 4'h3,
                                   4'hB, 4'hF, 4'h7, 4'h5, 4'hD, 4'h9, 4'h1, 4'h0, 4'h8};
        int dc, i;

        repeat (3) tick();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_wrap", {63'd0, wrap}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_idx", {32'd0, out_idx}, 64'd0);
        rst = 1'b0;
        tick();

        // Out-of-range dimension write must not touch the table.
        write_dir(2'd2, 5'd0, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) push(k, vdc[k], vdc[k]);
        dc = done_cnt;
        begin_run(32'd5, 1'b1);
        check("first_point_latency", {63'd0, out_valid}, 64'd1);
        check("busy_in_run", {63'd0, busy}, 64'd1);
        wait_done("vdc5", 50);
        check("vdc5_done_count", 64'(done_cnt - dc), 64'd1);

        write_dir(2'd1, 5'd0, 32'h8000_0000);
        write_dir(2'd1, 5'd1, 32'hC000_0000);
        write_dir(2'd1, 5'd2, 32'hA000_0000);
        for (int k = 0; k < 4; k++) push(k, vdc[k], tbl1[k]);
        begin_run(32'd4, 1'b1);
        wait_done("dim1_load", 50);

        // Stalled run with a dropped direction write in the middle.
        for (int k = 0; k < 8; k++) push(k, vdc[k], tbl1[k]);
        begin_run(32'd8, 1'b1);
        i = 0;
        while (!done && i < 100) begin
            out_ready = ~out_ready;
            dir_we = (i == 3); dir_dim = 2'd0; dir_bit = 5'd0; dir_data = 32'hFFFF_FFFF;
            tick();
            i++;
        end
        dir_we = 1'b0;
        out_ready = 1'b1;
        wait_done("stall", 5);

        start = 1'b1; clr = 1'b1; num_pts = 32'd4;
        tick();
        start = 1'b0; clr = 1'b0;
        check("clr_start_valid", {63'd0, out_valid}, 64'd0);
        check("clr_start_busy", {63'd0, busy}, 64'd0);

        for (int k = 0; k < 4; k++) push(k, vdc[k], tbl1[k]);
        dc = done_cnt;
        begin_run(32'd8, 1'b1);
        i = 0;
        while (out_idx != 32'd3 && i < 20) begin
            tick();
            i++;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_mid_valid", {63'd0, out_valid}, 64'd0);
        check("clr_mid_busy", {63'd0, busy}, 64'd0);
        tick();
        check("clr_mid_no_done", 64'(done_cnt - dc), 64'd0);
        check("clr_mid_queue", 64'(exp_q.size()), 64'd0);

        push(0, 4'h0, 4'h0);
        begin_run(32'd1, 1'b1);
        wait_done("single_point", 20);
        check("single_done_count", 64'(done_cnt - dc), 64'd1);

        // Reset mid-run restores the van der Corput table.
        write_dir(2'd1, 5'd0, 32'h1234_5678);
        push(0, 4'h0, 4'h0);
        begin_run(32'd0, 1'b0);
        repeat (3) tick();
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_idx", {32'd0, out_idx}, 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        push(0, 4'h0, 4'h0);
        push(1, 4'h8, 4'h8);
        begin_run(32'd2, 1'b1);
        wait_done("post_rst", 20);

        for (int k = 0; k < 18; k++) begin
            exp_t e;
            e.idx  = 32'(k % 16);
            e.data = {60'd0, w4seq[k]};
            s_q.push_back(e);
        end
        s_start = 1'b1; s_num_pts = 4'd0; s_ready = 1'b1;
        tick();
        s_start = 1'b0;
        i = 0;
        while (!s_wrap && i < 40) begin
            tick();
            i++;
        end
        check("w4_wrap_seen", {63'd0, s_wrap}, 64'd1);
        tick();
        check("w4_wrap_one_cycle", {63'd0, s_wrap}, 64'd0);
        check("w4_busy_after_wrap", {63'd0, s_busy}, 64'd1);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        check("w4_clr_idle", {63'd0, s_busy}, 64'd0);
        check("w4_wrap_count", 64'(wrap_cnt), 64'd1);
        check("w4_queue_drained", 64'(s_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
